// File: rtl/rvfi_trace_pkg.sv
// Shared types and constants for the RVFI trace generator: issue/retire
// records and the retire-side field masking rule.
package rvfi_trace_pkg;

  // Struct widths follow this constant; the top-level XLEN must match it.
  localparam int unsigned TRC_XLEN = 32;
  localparam int unsigned TRC_MW   = TRC_XLEN / 8;

  localparam logic [1:0] RVFI_MODE_M = 2'd3;
  localparam logic [1:0] RVFI_IXL_32 = 2'd1;

  typedef struct packed {
    logic [31:0]         insn;
    logic [TRC_XLEN-1:0] pc;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [TRC_XLEN-1:0] rs1_rdata;
    logic [TRC_XLEN-1:0] rs2_rdata;
  } issue_rec_t;

  typedef struct packed {
    logic                trap;
    logic [4:0]          rd_addr;
    logic [TRC_XLEN-1:0] rd_wdata;
    logic [TRC_XLEN-1:0] pc_wdata;
    logic [TRC_XLEN-1:0] mem_addr;
    logic [TRC_MW-1:0]   mem_rmask;
    logic [TRC_MW-1:0]   mem_wmask;
    logic [TRC_XLEN-1:0] mem_rdata;
    logic [TRC_XLEN-1:0] mem_wdata;
  } ret_rec_t;

  // x0 never reports a written value; a trapped instruction writes nothing.
  function automatic ret_rec_t mask_ret(input ret_rec_t r);
    ret_rec_t m;
    m = r;
    if (r.rd_addr == 5'd0) m.rd_wdata = '0;
    if (r.trap) begin
      m.rd_addr   = '0;
      m.rd_wdata  = '0;
      m.mem_rmask = '0;
      m.mem_wmask = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/rvfi_issue_fifo.sv
// In-order FIFO of issue records. A push coincident with flush survives and
// becomes the only entry; pops on empty and pushes on full are ignored.
module rvfi_issue_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       g_clk,
  input  logic       g_reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  issue_rec_t wr_data,
  output logic       full,
  output logic       empty,
  output issue_rec_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  issue_rec_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      if (flush)
        rd_ptr <= wr_ptr;
      else
        rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge g_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rvfi_trace_gen.sv
// RVFI producer: merges the head issue record with the retire event into one
// registered rvfi_* packet per retired instruction.
module rvfi_trace_gen
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = TRC_XLEN
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [31:0]       iss_insn,
  input  logic [XLEN-1:0]   iss_pc,
  input  logic [4:0]        iss_rs1_addr,
  input  logic [4:0]        iss_rs2_addr,
  input  logic [XLEN-1:0]   iss_rs1_rdata,
  input  logic [XLEN-1:0]   iss_rs2_rdata,
  input  logic              ret_valid,
  input  logic              ret_trap,
  input  logic [4:0]        ret_rd_addr,
  input  logic [XLEN-1:0]   ret_rd_wdata,
  input  logic [XLEN-1:0]   ret_pc_wdata,
  input  logic [XLEN-1:0]   ret_mem_addr,
  input  logic [XLEN/8-1:0] ret_mem_rmask,
  input  logic [XLEN/8-1:0] ret_mem_wmask,
  input  logic [XLEN-1:0]   ret_mem_rdata,
  input  logic [XLEN-1:0]   ret_mem_wdata,
  input  logic              flush,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_insn,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata,
  output logic              rvfi_trap,
  output logic              rvfi_halt,
  output logic              rvfi_intr,
  output logic [1:0]        rvfi_mode,
  output logic [1:0]        rvfi_ixl,
  output logic              trc_error
);

  issue_rec_t iss_rec;
  issue_rec_t head;
  ret_rec_t   ret_rec;
  ret_rec_t   ret_m;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_ok;
  logic [63:0] order_cnt;
  logic        intr_pending;

  assign iss_rec = '{insn: iss_insn, pc: iss_pc,
                     rs1_addr: iss_rs1_addr, rs2_addr: iss_rs2_addr,
                     rs1_rdata: iss_rs1_rdata, rs2_rdata: iss_rs2_rdata};

  assign ret_rec = '{trap: ret_trap, rd_addr: ret_rd_addr, rd_wdata: ret_rd_wdata,
                     pc_wdata: ret_pc_wdata, mem_addr: ret_mem_addr,
                     mem_rmask: ret_mem_rmask, mem_wmask: ret_mem_wmask,
                     mem_rdata: ret_mem_rdata, mem_wdata: ret_mem_wdata};
  assign ret_m   = mask_ret(ret_rec);

  assign iss_ready = !fifo_full;
  // A record pushed this cycle is not yet visible at the head, so no bypass.
  assign pop_ok    = ret_valid && !fifo_empty;
  assign rvfi_halt = 1'b0;
  assign rvfi_mode = RVFI_MODE_M;
  assign rvfi_ixl  = RVFI_IXL_32;

  rvfi_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (iss_valid),
    .pop     (pop_ok),
    .flush   (flush),
    .wr_data (iss_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // NOTE: all state here uses non-blocking assignment so every field of a
  // packet samples the same pre-edge values.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_trap      <= 1'b0;
      rvfi_intr      <= 1'b0;
      order_cnt      <= '0;
      intr_pending   <= 1'b0;
      trc_error      <= 1'b0;
    end else begin
      rvfi_valid <= pop_ok;
      if (ret_valid && fifo_empty) trc_error <= 1'b1;
      if (pop_ok) begin
        rvfi_order     <= order_cnt;
        rvfi_insn      <= head.insn;
        rvfi_pc_rdata  <= head.pc;
        rvfi_rs1_addr  <= head.rs1_addr;
        rvfi_rs2_addr  <= head.rs2_addr;
        rvfi_rs1_rdata <= head.rs1_rdata;
        rvfi_rs2_rdata <= head.rs2_rdata;
        rvfi_pc_wdata  <= ret_m.pc_wdata;
        rvfi_rd_addr   <= ret_m.rd_addr;
        rvfi_rd_wdata  <= ret_m.rd_wdata;
        rvfi_mem_addr  <= ret_m.mem_addr;
        rvfi_mem_rmask <= ret_m.mem_rmask;
        rvfi_mem_wmask <= ret_m.mem_wmask;
        rvfi_mem_rdata <= ret_m.mem_rdata;
        rvfi_mem_wdata <= ret_m.mem_wdata;
        rvfi_trap      <= ret_m.trap;
        rvfi_intr      <= intr_pending;
        intr_pending   <= ret_m.trap;
        order_cnt      <= order_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_trace_gen.sv
// Directed bench for rvfi_trace_gen with hand-computed expected packets.
module tb_rvfi_trace_gen;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_insn;
  logic [31:0] iss_pc;
  logic [4:0]  iss_rs1_addr;
  logic [4:0]  iss_rs2_addr;
  logic [31:0] iss_rs1_rdata;
  logic [31:0] iss_rs2_rdata;
  logic        ret_valid;
  logic        ret_trap;
  logic [4:0]  ret_rd_addr;
  logic [31:0] ret_rd_wdata;
  logic [31:0] ret_pc_wdata;
  logic [31:0] ret_mem_addr;
  logic [3:0]  ret_mem_rmask;
  logic [3:0]  ret_mem_wmask;
  logic [31:0] ret_mem_rdata;
  logic [31:0] ret_mem_wdata;
  logic        flush;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [1:0]  rvfi_ixl;
  logic        trc_error;

  int total = 0;
  int bad   = 0;

  rvfi_trace_gen #(.DEPTH(4), .XLEN(32)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_insn(iss_insn), .iss_pc(iss_pc),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_rs1_rdata(iss_rs1_rdata), .iss_rs2_rdata(iss_rs2_rdata),
    .ret_valid(ret_valid), .ret_trap(ret_trap), .ret_rd_addr(ret_rd_addr),
    .ret_rd_wdata(ret_rd_wdata), .ret_pc_wdata(ret_pc_wdata), .ret_mem_addr(ret_mem_addr),
    .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
    .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata), .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
    .trc_error(trc_error)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    g_reset = 1'b0; flush = 1'b0;
    iss_valid = 1'b0; iss_insn = '0; iss_pc = '0;
    iss_rs1_addr = '0; iss_rs2_addr = '0; iss_rs1_rdata = '0; iss_rs2_rdata = '0;
    ret_valid = 1'b0; ret_trap = 1'b0; ret_rd_addr = '0; ret_rd_wdata = '0;
    ret_pc_wdata = '0; ret_mem_addr = '0; ret_mem_rmask = '0; ret_mem_wmask = '0;
    ret_mem_rdata = '0; ret_mem_wdata = '0;
  endtask

  task automatic set_iss(input logic [31:0] insn, input logic [31:0] pc);
    iss_valid = 1'b1; iss_insn = insn; iss_pc = pc;
    iss_rs1_addr = insn[19:15]; iss_rs2_addr = insn[24:20];
    iss_rs1_rdata = pc + 32'h11; iss_rs2_rdata = pc + 32'h22;
  endtask

  task automatic set_ret(input logic [4:0] rd, input logic [31:0] wdata,
                         input logic trap, input logic [3:0] wmask);
    ret_valid = 1'b1; ret_trap = trap; ret_rd_addr = rd; ret_rd_wdata = wdata;
    ret_pc_wdata = wdata + 32'h4; ret_mem_wmask = wmask; ret_mem_rmask = wmask;
  endtask

  task automatic push_one(input logic [31:0] insn, input logic [31:0] pc);
    set_iss(insn, pc); tick(); iss_valid = 1'b0;
  endtask

  task automatic retire_one(input logic [4:0] rd, input logic [31:0] wdata,
                            input logic trap, input logic [3:0] wmask);
    set_ret(rd, wdata, trap, wmask); tick(); ret_valid = 1'b0; ret_trap = 1'b0;
  endtask

  task automatic do_reset();
    g_reset = 1'b1; tick(); tick(); g_reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check("rst_ready", iss_ready, 1);
    check("rst_valid", rvfi_valid, 0);
    check("rst_order", rvfi_order, 0);
    check("rst_insn", rvfi_insn, 0);
    check("rst_mode", rvfi_mode, 3);
    check("rst_ixl", rvfi_ixl, 1);
    check("rst_err", trc_error, 0);
    check("rst_intr", rvfi_intr, 0);

    // First instruction: addi x1,x0,5
    push_one(32'h0050_0093, 32'h8000_0000);
    check("t1_nopkt", rvfi_valid, 0);
    retire_one(5'd1, 32'd5, 1'b0, 4'h0);
    check("t1_valid", rvfi_valid, 1);
    check("t1_order", rvfi_order, 0);
    check("t1_insn", rvfi_insn, 32'h0050_0093);
    check("t1_pc", rvfi_pc_rdata, 32'h8000_0000);
    check("t1_pcw", rvfi_pc_wdata, 32'd9);
    check("t1_rs2a", rvfi_rs2_addr, 5);
    check("t1_rs1d", rvfi_rs1_rdata, 32'h8000_0011);
    check("t1_rd", rvfi_rd_addr, 1);
    check("t1_wdata", rvfi_rd_wdata, 5);
    check("t1_halt", rvfi_halt, 0);
    tick();
    check("t1_onecyc", rvfi_valid, 0);

    // Fill to full while holding iss_valid, then retire one
    iss_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_iss(32'h100 + i, 32'h1000 + 4 * i);
      tick();
    end
    check("full_ready", iss_ready, 0);
    set_iss(32'h104, 32'h1010);
    set_ret(5'd9, 32'h90, 1'b0, 4'h0);
    tick();
    ret_valid = 1'b0;
    check("full_pop_valid", rvfi_valid, 1);
    check("full_pop_insn", rvfi_insn, 32'h100);
    check("full_pop_order", rvfi_order, 1);
    check("full_ready_back", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    check("fifth_full", iss_ready, 0);
    for (int i = 1; i < 5; i++) begin
      retire_one(5'd9, 32'h90 + i, 1'b0, 4'h0);
      check($sformatf("fill_insn%0d", i), rvfi_insn, 32'h100 + i);
      check($sformatf("fill_pc%0d", i), rvfi_pc_rdata, 32'h1000 + 4 * i);
      check($sformatf("fill_ord%0d", i), rvfi_order, 1 + i);
    end

    // Masking and interrupt flag
    push_one(32'h300, 32'h3000);
    retire_one(5'd0, 32'hDEAD_BEEF, 1'b0, 4'h0);
    check("x0_wdata", rvfi_rd_wdata, 0);
    check("x0_order", rvfi_order, 6);
    push_one(32'h301, 32'h3004);
    retire_one(5'd3, 32'h7, 1'b1, 4'hF);
    check("trap_flag", rvfi_trap, 1);
    check("trap_wmask", rvfi_mem_wmask, 0);
    check("trap_rmask", rvfi_mem_rmask, 0);
    check("trap_rd", rvfi_rd_addr, 0);
    check("trap_wdata", rvfi_rd_wdata, 0);
    check("trap_intr", rvfi_intr, 0);
    push_one(32'h302, 32'h3008);
    retire_one(5'd2, 32'h9, 1'b0, 4'h3);
    check("intr_set", rvfi_intr, 1);
    check("intr_trap0", rvfi_trap, 0);
    check("intr_wdata", rvfi_rd_wdata, 9);
    check("intr_wmask", rvfi_mem_wmask, 3);
    push_one(32'h303, 32'h300C);
    retire_one(5'd2, 32'hA, 1'b0, 4'h0);
    check("intr_clear", rvfi_intr, 0);
    check("intr_order", rvfi_order, 9);

    // Retire + flush + push in one cycle
    push_one(32'h200, 32'h2000);
    push_one(32'h201, 32'h2004);
    push_one(32'h202, 32'h2008);
    set_iss(32'h2FF, 32'h20FC);
    set_ret(5'd4, 32'h44, 1'b0, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; iss_valid = 1'b0; ret_valid = 1'b0;
    check("fl_valid", rvfi_valid, 1);
    check("fl_insn", rvfi_insn, 32'h200);
    check("fl_order", rvfi_order, 10);
    retire_one(5'd4, 32'h45, 1'b0, 4'h0);
    check("fl_x_insn", rvfi_insn, 32'h2FF);
    check("fl_x_order", rvfi_order, 11);

    // Empty retire raises a sticky error
    retire_one(5'd4, 32'h46, 1'b0, 4'h0);
    check("emp_valid", rvfi_valid, 0);
    check("emp_err", trc_error, 1);
    tick();
    check("emp_err_held", trc_error, 1);
    push_one(32'h400, 32'h4000);
    retire_one(5'd5, 32'h50, 1'b0, 4'h0);
    check("emp_order_kept", rvfi_order, 12);
    check("emp_insn", rvfi_insn, 32'h400);

    do_reset();
    check("rst2_err", trc_error, 0);
    check("rst2_order", rvfi_order, 0);

    // Same-cycle push and retire on empty FIFO: no bypass
    set_iss(32'h500, 32'h5000);
    set_ret(5'd6, 32'h60, 1'b0, 4'h0);
    tick();
    iss_valid = 1'b0; ret_valid = 1'b0;
    check("byp_valid", rvfi_valid, 0);
    check("byp_err", trc_error, 1);
    retire_one(5'd6, 32'h61, 1'b0, 4'h0);
    check("byp_insn", rvfi_insn, 32'h500);
    check("byp_order", rvfi_order, 0);

    // Reset with records queued drops them
    do_reset();
    push_one(32'h600, 32'h6000);
    push_one(32'h601, 32'h6004);
    g_reset = 1'b1;
    set_ret(5'd7, 32'h70, 1'b0, 4'h0);
    tick();
    ret_valid = 1'b0;
    tick();
    g_reset = 1'b0;
    check("rst3_valid", rvfi_valid, 0);
    check("rst3_ready", iss_ready, 1);
    retire_one(5'd7, 32'h71, 1'b0, 4'h0);
    check("rst3_nopkt", rvfi_valid, 0);
    check("rst3_err", trc_error, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
